// File: rtl/fa_button_cond.sv
// fa_button_cond: conditions the raw call and cancel push-buttons for the
// flight-attendant call controller. Each button is synchronised and debounced,
// and each debounced press becomes exactly one single-cycle pulse. When both
// buttons are accepted on the same edge, cancel wins.

// One button channel: two-flop synchroniser plus debounce FSM.
// press_req is high for the single cycle in which a press is accepted.
module fa_button_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press_req,
    output logic held
);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        DN_PEND = 2'd1,
        DOWN    = 2'd2,
        UP_PEND = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_s1;
    logic             sync_s2;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; sync_s2 is the level the debouncer trusts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
        end else begin
            sync_s1 <= raw;
            sync_s2 <= sync_s1;
        end
    end

    // A press is accepted on the edge where the last pending-down sample arrives.
    assign press_req = (state == DN_PEND) && sync_s2 && (cnt == CNT_LAST);

    // Debounce FSM: a level change needs DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UP;
            cnt   <= '0;
            held  <= 1'b0;
        end else begin
            case (state)
                UP: begin
                    if (sync_s2) begin
                        state <= DN_PEND;
                        cnt   <= CNT_ONE;
                    end
                end
                DN_PEND: begin
                    if (!sync_s2) begin
                        state <= UP;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= DOWN;
                        cnt   <= '0;
                        held  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!sync_s2) begin
                        state <= UP_PEND;
                        cnt   <= CNT_ONE;
                    end
                end
                UP_PEND: begin
                    if (sync_s2) begin
                        state <= DOWN;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= UP;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= UP;
                    cnt   <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// Top level: two identical channels and the cancel-wins pulse register.
module fa_button_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic call_raw,
    input  logic cancel_raw,
    output logic call_button,
    output logic cancel_button,
    output logic call_held,
    output logic cancel_held
);

    logic call_req;
    logic cancel_req;

    fa_button_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_call_chan (
        .clk      (clk),
        .reset    (reset),
        .raw      (call_raw),
        .press_req(call_req),
        .held     (call_held)
    );

    fa_button_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_cancel_chan (
        .clk      (clk),
        .reset    (reset),
        .raw      (cancel_raw),
        .press_req(cancel_req),
        .held     (cancel_held)
    );

    // Register the pulses; a call accepted together with a cancel is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            call_button   <= 1'b0;
            cancel_button <= 1'b0;
        end else begin
            cancel_button <= cancel_req;
            call_button   <= call_req && !cancel_req;
        end
    end

endmodule

// File: tb/tb_fa_button_cond.sv
// Testbench for fa_button_cond: table-driven vectors, hand-written corner-case
// sequences and randomized stimulus against a run-length reference model.
module tb_fa_button_cond;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic call_raw = 1'b0;
    logic cancel_raw = 1'b0;
    logic call_button;
    logic cancel_button;
    logic call_held;
    logic cancel_held;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: index 0 = call, 1 = cancel.
    bit m_s1 [2];
    bit m_s2 [2];
    bit run_val [2];
    int run_len [2];
    bit lvl [2];
    bit req [2];
    bit exp_cb = 1'b0;
    bit exp_kb = 1'b0;
    bit exp_ch = 1'b0;
    bit exp_kh = 1'b0;

    typedef struct {
        logic call_raw;
        logic cancel_raw;
        logic exp_call_button;
        logic exp_cancel_button;
        logic exp_call_held;
        logic exp_cancel_held;
    } vec_t;

    vec_t vecs [36];

    fa_button_cond #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .call_raw     (call_raw),
        .cancel_raw   (cancel_raw),
        .call_button  (call_button),
        .cancel_button(cancel_button),
        .call_held    (call_held),
        .cancel_held  (cancel_held)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Set the raw buttons, let one rising edge sample them, then settle 1 time unit.
    task automatic applyStimulus(input logic cr, input logic kr);
        call_raw   = cr;
        cancel_raw = kr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    // Reference model: a level is accepted once DEB consecutive synchronised
    // samples agree; a newly accepted high level is a press, cancel wins ties.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int c = 0; c < 2; c++) begin
                    m_s1[c] = 1'b0;
                    m_s2[c] = 1'b0;
                    run_val[c] = 1'b0;
                    run_len[c] = 0;
                    lvl[c] = 1'b0;
                end
                exp_cb = 1'b0;
                exp_kb = 1'b0;
                exp_ch = 1'b0;
                exp_kh = 1'b0;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (m_s2[c] == run_val[c]) begin
                        if (run_len[c] < DEB) run_len[c]++;
                    end else begin
                        run_val[c] = m_s2[c];
                        run_len[c] = 1;
                    end
                    req[c] = 1'b0;
                    if (run_len[c] >= DEB && run_val[c] != lvl[c]) begin
                        req[c] = run_val[c];
                        lvl[c] = run_val[c];
                    end
                end
                exp_kb = req[1];
                exp_cb = req[0] & ~req[1];
                exp_ch = lvl[0];
                exp_kh = lvl[1];
                m_s2[0] = m_s1[0];
                m_s2[1] = m_s1[1];
                m_s1[0] = call_raw;
                m_s1[1] = cancel_raw;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_call_button", call_button, exp_cb);
            checkOutput("model_cancel_button", cancel_button, exp_kb);
            checkOutput("model_call_held", call_held, exp_ch);
            checkOutput("model_cancel_held", cancel_held, exp_kh);
        end
    end

    initial begin
        int pulses;
        int hold_left [2];
        logic rnd [2];

        $display("[TB] start");

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_call_button", call_button, 1'b0);
        checkOutput("reset_cancel_button", cancel_button, 1'b0);
        checkOutput("reset_call_held", call_held, 1'b0);
        checkOutput("reset_cancel_held", cancel_held, 1'b0);
        reset = 1'b0;
        chk_en = 1'b1;
        idle(4);

        // Table: simultaneous press then staggered press
        for (int i = 0; i < 18; i++) begin
            vecs[i].call_raw          = (i < 10);
            vecs[i].cancel_raw        = (i < 10);
            vecs[i].exp_call_button   = 1'b0;
            vecs[i].exp_cancel_button = (i == 5);
            vecs[i].exp_call_held     = (i >= 5 && i < 15);
            vecs[i].exp_cancel_held   = (i >= 5 && i < 15);
        end
        for (int j = 0; j < 18; j++) begin
            vecs[18 + j].call_raw          = (j < 10);
            vecs[18 + j].cancel_raw        = (j >= 1 && j < 10);
            vecs[18 + j].exp_call_button   = (j == 5);
            vecs[18 + j].exp_cancel_button = (j == 6);
            vecs[18 + j].exp_call_held     = (j >= 5 && j < 15);
            vecs[18 + j].exp_cancel_held   = (j >= 6 && j < 15);
        end
        for (int i = 0; i < 36; i++) begin
            applyStimulus(vecs[i].call_raw, vecs[i].cancel_raw);
            checkOutput("tbl_call_button", call_button, vecs[i].exp_call_button);
            checkOutput("tbl_cancel_button", cancel_button, vecs[i].exp_cancel_button);
            checkOutput("tbl_call_held", call_held, vecs[i].exp_call_held);
            checkOutput("tbl_cancel_held", cancel_held, vecs[i].exp_cancel_held);
        end
        idle(8);

        // Clean press held 20 cycles, then released
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            applyStimulus(1'b1, 1'b0);
            if (call_button) pulses++;
            checkOutput("clean_call_button", call_button, (j == 5));
            checkOutput("clean_call_held", call_held, (j >= 5));
            checkOutput("clean_cancel_button", cancel_button, 1'b0);
        end
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b0, 1'b0);
            if (call_button) pulses++;
            checkOutput("release_call_held", call_held, (j < 5));
        end
        checkCount("clean_pulse_count", pulses, 1);
        idle(4);

        // Bounce: high 2, low 1, high 2, low 1, then held
        pulses = 0;
        for (int j = 0; j < 18; j++) begin
            applyStimulus(!(j == 2 || j == 5), 1'b0);
            if (call_button) pulses++;
            checkOutput("bounce_call_button", call_button, (j == 11));
        end
        checkCount("bounce_pulse_count", pulses, 1);

        // Release glitch while held: low 2 cycles then high again
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(!(j == 0 || j == 1), 1'b0);
            if (call_button) pulses++;
            checkOutput("glitch_call_held", call_held, 1'b1);
        end
        checkCount("glitch_pulse_count", pulses, 0);
        idle(8);

        // Reset mid-pending, with cancel already held so the clear is visible
        for (int j = 0; j < 8; j++) applyStimulus(1'b0, 1'b1);
        checkOutput("pre_reset_cancel_held", cancel_held, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        reset = 1'b1;
        cancel_raw = 1'b0;
        #1;
        checkOutput("async_reset_cancel_held", cancel_held, 1'b0);
        checkOutput("async_reset_call_button", call_button, 1'b0);
        for (int j = 0; j < 2; j++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("in_reset_call_button", call_button, 1'b0);
            checkOutput("in_reset_call_held", call_held, 1'b0);
        end
        reset = 1'b0;
        pulses = 0;
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b1, 1'b0);
            if (call_button) pulses++;
            checkOutput("post_reset_call_button", call_button, (j == 5));
        end
        checkCount("post_reset_pulse_count", pulses, 1);
        idle(8);

        // Randomized segments of random length, occasional async reset
        hold_left[0] = 0;
        hold_left[1] = 0;
        rnd[0] = 1'b0;
        rnd[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold_left[c] == 0) begin
                    rnd[c] = ~rnd[c];
                    hold_left[c] = int'($urandom_range(1, 9));
                end
                hold_left[c]--;
            end
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                #1;
                checkOutput("rnd_reset_call_button", call_button, 1'b0);
                checkOutput("rnd_reset_cancel_held", cancel_held, 1'b0);
                applyStimulus(rnd[0], rnd[1]);
                reset = 1'b0;
            end else begin
                applyStimulus(rnd[0], rnd[1]);
            end
        end
        idle(8);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
